// File: rtl/rename_reg_file_if.sv
// Dispatcher/RoB-facing bundle for the rename register file.
//   Commit side : commit_en, commit_rd, commit_rob, commit_data
//   Rename side : rename_en, rename_rd, rename_rob
//   Read side   : rd_addr (in), rd_val / rd_busy / rd_tag (out), NUM_RD ports packed
//                 with port i at [i*W +: W]
// master = Dispatcher/RoB side, slave = register file.
// Parameters must match those of the rename_reg_file instance it is bound to.
interface rename_reg_file_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned ROB_W   = 3,
    parameter int unsigned NUM_RD  = 2
);
    localparam int unsigned RI = $clog2(REG_NUM);

    logic                    commit_en;
    logic [RI-1:0]           commit_rd;
    logic [ROB_W-1:0]        commit_rob;
    logic [XLEN-1:0]         commit_data;

    logic                    rename_en;
    logic [RI-1:0]           rename_rd;
    logic [ROB_W-1:0]        rename_rob;

    logic [NUM_RD*RI-1:0]    rd_addr;
    logic [NUM_RD*XLEN-1:0]  rd_val;
    logic [NUM_RD-1:0]       rd_busy;
    logic [NUM_RD*ROB_W-1:0] rd_tag;

    modport master (
        output commit_en, commit_rd, commit_rob, commit_data,
        output rename_en, rename_rd, rename_rob,
        output rd_addr,
        input  rd_val, rd_busy, rd_tag
    );

    modport slave (
        input  commit_en, commit_rd, commit_rob, commit_data,
        input  rename_en, rename_rd, rename_rob,
        input  rd_addr,
        output rd_val, rd_busy, rd_tag
    );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tags (Tomasulo core).
// Each register holds {value, busy, tag}. The Dispatcher renames a destination to a RoB
// entry; the RoB commits values and clears the busy bit when the committing entry is still
// the register's newest producer; a RoB flush drops all pending renames.
// Ports:
//   clk_in   : clock, rising edge
//   rst_in   : asynchronous reset, active low (clears value, busy and tag)
//   rdy_in   : 1 = run, 0 = hold all state (reads still live)
//   flush_in : mispredict flush, clears every busy bit, blocks same-cycle rename
//   bus      : commit / rename / read bundle (slave side)
// Reads are combinational with a same-cycle commit bypass; register 0 reads as zero and
// out-of-range addresses read as zero and not busy.
module rename_reg_file #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned ROB_W   = 3,
    parameter int unsigned NUM_RD  = 2
) (
    input logic              clk_in,
    input logic              rst_in,
    input logic              rdy_in,
    input logic              flush_in,
    rename_reg_file_if.slave bus
);
    localparam int unsigned RI = $clog2(REG_NUM);

    logic [REG_NUM-1:0][XLEN-1:0]  val_q, val_d;
    logic [REG_NUM-1:0]            busy_q, busy_d;
    logic [REG_NUM-1:0][ROB_W-1:0] tag_q, tag_d;

    logic commit_ok;
    logic rename_ok;

    assign commit_ok = bus.commit_en && (bus.commit_rd != '0) && (32'(bus.commit_rd) < REG_NUM);
    assign rename_ok = bus.rename_en && (bus.rename_rd != '0) && (32'(bus.rename_rd) < REG_NUM);

    // Next state. Commit is applied first so a same-cycle rename of the same register
    // overrides its busy/tag while the committed value is still written.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy_in) begin
            if (commit_ok) begin
                // In-order commit: the value is always the latest architectural one.
                val_d[bus.commit_rd] = bus.commit_data;
                // A younger rename keeps the register busy.
                if (tag_q[bus.commit_rd] == bus.commit_rob) begin
                    busy_d[bus.commit_rd] = 1'b0;
                end
            end
            if (flush_in) begin
                busy_d = '0;
            end else if (rename_ok) begin
                busy_d[bus.rename_rd] = 1'b1;
                tag_d[bus.rename_rd]  = bus.rename_rob;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            val_q  <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    logic [NUM_RD-1:0][XLEN-1:0]  rd_val_w;
    logic [NUM_RD-1:0]            rd_busy_w;
    logic [NUM_RD-1:0][ROB_W-1:0] rd_tag_w;
    logic [RI-1:0]                addr;

    // Read ports. Bypass ignores rdy_in and flush_in: the RoB is handing over the value
    // this cycle regardless of whether the file updates.
    always_comb begin
        rd_val_w  = '0;
        rd_busy_w = '0;
        rd_tag_w  = '0;
        addr      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            addr = bus.rd_addr[i*RI +: RI];
            if ((addr != '0) && (32'(addr) < REG_NUM)) begin
                if (bus.commit_en && busy_q[addr] && (tag_q[addr] == bus.commit_rob) &&
                    (bus.commit_rd == addr)) begin
                    rd_val_w[i]  = bus.commit_data;
                    rd_busy_w[i] = 1'b0;
                    rd_tag_w[i]  = tag_q[addr];
                end else begin
                    rd_val_w[i]  = val_q[addr];
                    rd_busy_w[i] = busy_q[addr];
                    rd_tag_w[i]  = tag_q[addr];
                end
            end
        end
    end

    assign bus.rd_val  = rd_val_w;
    assign bus.rd_busy = rd_busy_w;
    assign bus.rd_tag  = rd_tag_w;
endmodule
